// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the writeback stage.
// Contents:
//   - wb_sel encodings selecting the retiring result source
//   - load funct3 encodings (width / signedness)
//   - writeback FSM state enum
//   - link_addr(): PC+4 link value from a word PC, wrapping mod 2^32
package pipeline_pkg;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_CSR  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [0:0] {
      WB_IDLE      = 1'b0,
      WB_WAIT_LOAD = 1'b1
   } wb_state_e;

   // Byte address of the following instruction; the 32-bit add wraps naturally.
   function automatic logic [31:0] link_addr(input logic [29:0] pc);
      return {pc, 2'b00} + 32'd4;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data aligner / extender.
// Ports:
//   word    in  32  raw data-memory read word
//   addr_lo in  2   low byte-address bits of the load
//   funct3  in  3   load width/sign encoding
//   result  out 32  aligned, sign- or zero-extended load value
module load_extend
   import pipeline_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte lane of the read word.
   always_comb begin
      byte_s = word[7:0];
      case (addr_lo)
         2'b00:   byte_s = word[7:0];
         2'b01:   byte_s = word[15:8];
         2'b10:   byte_s = word[23:16];
         2'b11:   byte_s = word[31:24];
         default: byte_s = word[7:0];
      endcase
   end

   // Halfword lane is chosen by addr_lo[1] only; misalignment is not handled here.
   assign half_s = addr_lo[1] ? word[31:16] : word[15:0];

   // Extend according to width/sign; LW and unknown codes pass the full word.
   always_comb begin
      result = word;
      case (funct3)
         F3_LB:   result = {{24{byte_s[7]}}, byte_s};
         F3_LBU:  result = {24'h000000, byte_s};
         F3_LH:   result = {{16{half_s[15]}}, half_s};
         F3_LHU:  result = {16'h0000, half_s};
         F3_LW:   result = word;
         default: result = word;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the retiring result, waits for load data,
// drives the register-file write port and counts retired instructions.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   busywait_i              global freeze; blocks capture of new instructions
//   valid_i                 memory stage holds a real instruction
//   pc_i[29:0]              word PC of incoming instruction
//   alu_result_i[31:0]      ALU result / load byte address
//   csr_data_i[31:0]        old CSR value
//   wb_sel_i[1:0]           result source (ALU / LOAD / PC+4 / CSR)
//   rd_i[4:0]               destination register, 0 = no write
//   funct3_i[2:0]           load width/sign encoding
//   is_load_instr_i         instruction is a load
//   dmem_rdata_i, dmem_rvalid_i  data-memory read response
//   wb_stall_o              high while waiting for load data
//   rd_label_o, rd_data_o   one-cycle register-file write pulse
//   instret_o               retired-instruction counter
module writeback_stage
   import pipeline_pkg::*;
#(
   parameter int INSTRET_W     = 64,
   parameter int RESET_PC_ZERO = 1
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 busywait_i,
   input  logic                 valid_i,
   input  logic [29:0]          pc_i,
   input  logic [31:0]          alu_result_i,
   input  logic [31:0]          csr_data_i,
   input  logic [1:0]           wb_sel_i,
   input  logic [4:0]           rd_i,
   input  logic [2:0]           funct3_i,
   input  logic                 is_load_instr_i,
   input  logic [31:0]          dmem_rdata_i,
   input  logic                 dmem_rvalid_i,
   output logic                 wb_stall_o,
   output logic [4:0]           rd_label_o,
   output logic [31:0]          rd_data_o,
   output logic [INSTRET_W-1:0] instret_o
);

   // Reserved parameter: only the value 1 is meaningful, nothing depends on it.
   if (RESET_PC_ZERO != 1) begin : g_reserved_reset_pc
   end

   wb_state_e             state_r, state_nxt_s;
   logic [4:0]            ld_rd_r;
   logic [2:0]            ld_funct3_r;
   logic [1:0]            ld_addr_lo_r;
   logic [4:0]            rd_label_r;
   logic [31:0]           rd_data_r;
   logic [INSTRET_W-1:0]  instret_r;

   logic [31:0]           sel_data_s;
   logic [31:0]           ext_data_s;
   logic                  retire_s;
   logic                  latch_ld_s;
   logic [4:0]            wr_label_s;
   logic [31:0]           wr_data_s;

   load_extend u_load_extend (
      .word    (dmem_rdata_i),
      .addr_lo (ld_addr_lo_r),
      .funct3  (ld_funct3_r),
      .result  (ext_data_s)
   );

   // Result source mux for non-load instructions.
   always_comb begin
      sel_data_s = alu_result_i;
      case (wb_sel_i)
         WB_ALU:  sel_data_s = alu_result_i;
         WB_LOAD: sel_data_s = alu_result_i;
         WB_PC4:  sel_data_s = link_addr(pc_i);
         WB_CSR:  sel_data_s = csr_data_i;
         default: sel_data_s = alu_result_i;
      endcase
   end

   // Next-state and retire decision. A load response arriving during a freeze
   // still completes: the memory cannot replay it.
   always_comb begin
      state_nxt_s = state_r;
      retire_s    = 1'b0;
      latch_ld_s  = 1'b0;
      wr_label_s  = 5'd0;
      wr_data_s   = sel_data_s;
      case (state_r)
         WB_IDLE: begin
            if (valid_i && !busywait_i) begin
               if (is_load_instr_i) begin
                  latch_ld_s  = 1'b1;
                  state_nxt_s = WB_WAIT_LOAD;
               end else begin
                  retire_s   = 1'b1;
                  wr_label_s = rd_i;
                  wr_data_s  = sel_data_s;
               end
            end else begin
               state_nxt_s = WB_IDLE;
            end
         end
         WB_WAIT_LOAD: begin
            if (dmem_rvalid_i) begin
               retire_s    = 1'b1;
               wr_label_s  = ld_rd_r;
               wr_data_s   = ext_data_s;
               state_nxt_s = WB_IDLE;
            end else begin
               state_nxt_s = WB_WAIT_LOAD;
            end
         end
         default: state_nxt_s = WB_IDLE;
      endcase
   end

   // State, load context, write-port pulse and retire counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= WB_IDLE;
         ld_rd_r      <= 5'd0;
         ld_funct3_r  <= 3'd0;
         ld_addr_lo_r <= 2'd0;
         rd_label_r   <= 5'd0;
         rd_data_r    <= 32'd0;
         instret_r    <= {INSTRET_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (latch_ld_s) begin
            ld_rd_r      <= rd_i;
            ld_funct3_r  <= funct3_i;
            ld_addr_lo_r <= alu_result_i[1:0];
         end
         // Label pulses for exactly one cycle; data holds across non-write cycles.
         rd_label_r <= retire_s ? wr_label_s : 5'd0;
         if (retire_s && (wr_label_s != 5'd0)) begin
            rd_data_r <= wr_data_s;
         end
         if (retire_s) begin
            instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign wb_stall_o = (state_r == WB_WAIT_LOAD);
   assign rd_label_o = rd_label_r;
   assign rd_data_o  = rd_data_r;
   assign instret_o  = instret_r;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        busywait_i;
   logic        valid_i;
   logic [29:0] pc_i;
   logic [31:0] alu_result_i;
   logic [31:0] csr_data_i;
   logic [1:0]  wb_sel_i;
   logic [4:0]  rd_i;
   logic [2:0]  funct3_i;
   logic        is_load_instr_i;
   logic [31:0] dmem_rdata_i;
   logic        dmem_rvalid_i;
   logic        wb_stall_o;
   logic [4:0]  rd_label_o;
   logic [31:0] rd_data_o;
   logic [63:0] instret_o;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [63:0] exp_ir = 64'd0;
   logic [31:0] last_data;

   writeback_stage #(.INSTRET_W(64), .RESET_PC_ZERO(1)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .busywait_i      (busywait_i),
      .valid_i         (valid_i),
      .pc_i            (pc_i),
      .alu_result_i    (alu_result_i),
      .csr_data_i      (csr_data_i),
      .wb_sel_i        (wb_sel_i),
      .rd_i            (rd_i),
      .funct3_i        (funct3_i),
      .is_load_instr_i (is_load_instr_i),
      .dmem_rdata_i    (dmem_rdata_i),
      .dmem_rvalid_i   (dmem_rvalid_i),
      .wb_stall_o      (wb_stall_o),
      .rd_label_o      (rd_label_o),
      .rd_data_o       (rd_data_o),
      .instret_o       (instret_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Issue a load, return its data on the very next cycle, check the write.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
      valid_i = 1'b1; is_load_instr_i = 1'b1; wb_sel_i = 2'b01;
      funct3_i = f3; alu_result_i = addr; rd_i = rd;
      step();
      valid_i = 1'b0; is_load_instr_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
      step();
      dmem_rvalid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check({tag, "_label"}, {59'd0, rd_label_o}, {59'd0, rd});
      check({tag, "_data"}, {32'd0, rd_data_o}, {32'd0, exp});
      check({tag, "_instret"}, instret_o, exp_ir);
   endtask

   initial begin
      rst_i = 1'b1; busywait_i = 1'b0; valid_i = 1'b0; pc_i = 30'd0;
      alu_result_i = 32'd0; csr_data_i = 32'd0; wb_sel_i = 2'b00; rd_i = 5'd0;
      funct3_i = 3'd0; is_load_instr_i = 1'b0; dmem_rdata_i = 32'd0; dmem_rvalid_i = 1'b0;
      step(); step();
      rst_i = 1'b0;
      check("rst_label", {59'd0, rd_label_o}, 64'd0);
      check("rst_data", {32'd0, rd_data_o}, 64'd0);
      check("rst_instret", instret_o, 64'd0);
      check("rst_stall", {63'd0, wb_stall_o}, 64'd0);

      // ALU op
      valid_i = 1'b1; wb_sel_i = 2'b00; rd_i = 5'd5; alu_result_i = 32'h12345678;
      step();
      valid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check("alu_label", {59'd0, rd_label_o}, 64'd5);
      check("alu_data", {32'd0, rd_data_o}, 64'h12345678);
      check("alu_instret", instret_o, exp_ir);
      step();
      check("alu_pulse_end", {59'd0, rd_label_o}, 64'd0);
      check("alu_data_hold", {32'd0, rd_data_o}, 64'h12345678);

      // JAL link at PC wrap
      valid_i = 1'b1; wb_sel_i = 2'b10; pc_i = 30'h3FFFFFFF; rd_i = 5'd1;
      step();
      valid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check("jal_label", {59'd0, rd_label_o}, 64'd1);
      check("jal_data", {32'd0, rd_data_o}, 64'h0);

      // CSR read
      valid_i = 1'b1; wb_sel_i = 2'b11; csr_data_i = 32'hCAFEF00D; rd_i = 5'd9;
      step();
      valid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check("csr_data", {32'd0, rd_data_o}, 64'hCAFEF00D);
      check("csr_instret", instret_o, exp_ir);

      // LB, lane 3, 3-cycle wait; rvalid in the capture cycle must be ignored
      valid_i = 1'b1; is_load_instr_i = 1'b1; wb_sel_i = 2'b01; funct3_i = 3'b000;
      alu_result_i = 32'h00001003; rd_i = 5'd7;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h11111111;
      step();
      valid_i = 1'b0; is_load_instr_i = 1'b0; dmem_rvalid_i = 1'b0;
      check("lb_stall1", {63'd0, wb_stall_o}, 64'd1);
      check("lb_wait_label1", {59'd0, rd_label_o}, 64'd0);
      step();
      check("lb_stall2", {63'd0, wb_stall_o}, 64'd1);
      step();
      check("lb_stall3", {63'd0, wb_stall_o}, 64'd1);
      check("lb_wait_instret", instret_o, exp_ir);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF00AA;
      step();
      dmem_rvalid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check("lb_stall_done", {63'd0, wb_stall_o}, 64'd0);
      check("lb_label", {59'd0, rd_label_o}, 64'd7);
      check("lb_data", {32'd0, rd_data_o}, 64'hFFFFFF80);
      check("lb_instret", instret_o, exp_ir);
      step();
      check("lb_pulse_end", {59'd0, rd_label_o}, 64'd0);

      do_load("lhu", 3'b101, 32'h00000002, 5'd8,  32'hBEEF1234, 32'h0000BEEF);
      do_load("lh",  3'b001, 32'h00000002, 5'd8,  32'hBEEF1234, 32'hFFFFBEEF);
      do_load("lh_lo", 3'b001, 32'h00000000, 5'd10, 32'hBEEF8234, 32'hFFFF8234);
      do_load("lbu", 3'b100, 32'h00000001, 5'd11, 32'h1234F6CC, 32'h000000F6);
      do_load("lb0", 3'b000, 32'h00000000, 5'd12, 32'h1234F67C, 32'h0000007C);
      do_load("lw",  3'b010, 32'h00000003, 5'd13, 32'hDEADBEEF, 32'hDEADBEEF);
      do_load("f3_other", 3'b011, 32'h00000001, 5'd14, 32'h87654321, 32'h87654321);

      // Freeze for 2 cycles with a valid instruction waiting
      valid_i = 1'b1; wb_sel_i = 2'b00; rd_i = 5'd3; alu_result_i = 32'hA5A5A5A5;
      busywait_i = 1'b1;
      step();
      check("bw1_label", {59'd0, rd_label_o}, 64'd0);
      check("bw1_instret", instret_o, exp_ir);
      step();
      check("bw2_label", {59'd0, rd_label_o}, 64'd0);
      check("bw2_instret", instret_o, exp_ir);
      busywait_i = 1'b0;
      step();
      valid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check("bw_rel_label", {59'd0, rd_label_o}, 64'd3);
      check("bw_rel_data", {32'd0, rd_data_o}, 64'hA5A5A5A5);
      check("bw_rel_instret", instret_o, exp_ir);
      step();
      check("bw_once_label", {59'd0, rd_label_o}, 64'd0);
      check("bw_once_instret", instret_o, exp_ir);

      // Bubble with nonzero rd is ignored
      valid_i = 1'b0; rd_i = 5'd12; alu_result_i = 32'h0BADF00D;
      step();
      check("bubble_label", {59'd0, rd_label_o}, 64'd0);
      check("bubble_instret", instret_o, exp_ir);
      check("bubble_data_hold", {32'd0, rd_data_o}, 64'hA5A5A5A5);

      // rd=0 retires but produces no write label
      valid_i = 1'b1; rd_i = 5'd0; alu_result_i = 32'h55555555;
      step();
      valid_i = 1'b0;
      exp_ir = exp_ir + 64'd1;
      check("rd0_label", {59'd0, rd_label_o}, 64'd0);
      check("rd0_instret", instret_o, exp_ir);

      // Reset during WAIT_LOAD aborts the load
      valid_i = 1'b1; is_load_instr_i = 1'b1; wb_sel_i = 2'b01; funct3_i = 3'b010;
      alu_result_i = 32'h00000000; rd_i = 5'd4;
      step();
      valid_i = 1'b0; is_load_instr_i = 1'b0;
      check("rstwait_stall", {63'd0, wb_stall_o}, 64'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h77777777;
      step();
      dmem_rvalid_i = 1'b0;
      check("rstwait_label", {59'd0, rd_label_o}, 64'd0);
      check("rstwait_instret", instret_o, 64'd0);
      check("rstwait_stall_low", {63'd0, wb_stall_o}, 64'd0);
      check("rstwait_data", {32'd0, rd_data_o}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
